axi_stream_pkt_fifo: RTL

AXI_STREAM_PKT_FIFO -- requirements
Module: axi_stream_pkt_fifo

---
 rtl/axis_pkg.sv | 16 +
 rtl/axi_stream_fifo_mem.sv | 27 ++
 rtl/axi_stream_pkt_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO: default data width,
// keep-width derivation and the packet-mode state encoding.
package axis_pkg;

    localparam int DEFAULT_TDATA_WIDTH = 32;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    typedef enum logic {
        STORE = 1'b0,
        CUT   = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/axi_stream_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read so the
// head entry can fall through to the output without a cycle of latency.
module axi_stream_fifo_mem #(
    parameter int WIDTH = 37,
    parameter int ADDR_W = 4
) (
    input  logic              aclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int ENTRIES = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_array [ENTRIES];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_array[rd_addr];

endmodule

// File: rtl/axi_stream_pkt_fifo.sv
// Packet-mode AXI-Stream FIFO: holds beats until a whole packet is stored,
// and falls back to cut-through when a packet is larger than the buffer.
module axi_stream_pkt_fifo
    import axis_pkg::*;
#(
    parameter int TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
    parameter int DEPTH       = 16
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [TDATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [keep_width(TDATA_WIDTH)-1:0]   s_axis_tkeep,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    output logic [TDATA_WIDTH-1:0]               m_axis_tdata,
    output logic [keep_width(TDATA_WIDTH)-1:0]   m_axis_tkeep,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    output logic [$clog2(DEPTH):0]               occupancy,
    output logic [$clog2(DEPTH):0]               pkt_count
);

    localparam int KEEP_W  = keep_width(TDATA_WIDTH);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = TDATA_WIDTH + KEEP_W + 1;
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               ready_en;
    pkt_state_e         state;
    pkt_state_e         state_next;
    logic               wr_fire;
    logic               rd_fire;
    logic               wr_pkt;
    logic               rd_pkt;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // ready_en holds tready low through reset and the first clock after it
    assign s_axis_tready = ready_en && (occupancy != FULL_COUNT);
    assign wr_fire       = s_axis_tvalid && s_axis_tready;
    assign rd_fire       = m_axis_tvalid && m_axis_tready;
    assign wr_pkt        = wr_fire && s_axis_tlast;
    assign rd_pkt        = rd_fire && m_axis_tlast;
    assign wr_entry      = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_entry;

    axi_stream_fifo_mem #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (AW)
    ) u_mem (
        .aclk    (aclk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            pkt_count <= '0;
            state     <= STORE;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            state    <= state_next;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
            case ({wr_pkt, rd_pkt})
                2'b10:   pkt_count <= pkt_count + (AW+1)'(1);
                2'b01:   pkt_count <= pkt_count - (AW+1)'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // A full buffer with no complete packet can never drain in STORE,
    // so switch to cut-through until that packet's last beat leaves.
    always_comb begin
        state_next    = state;
        m_axis_tvalid = 1'b0;
        case (state)
            STORE: begin
                m_axis_tvalid = (pkt_count != '0) && (occupancy != '0);
                if ((occupancy == FULL_COUNT) && (pkt_count == '0)) begin
                    state_next = CUT;
                end
            end
            CUT: begin
                m_axis_tvalid = (occupancy != '0);
                if (rd_pkt) begin
                    state_next = STORE;
                end
            end
            default: state_next = STORE;
        endcase
    end

endmodule
